// File: rtl/rhythm_pkg.sv
// Constants and grade type shared by the pattern, judge and renderer blocks.
package rhythm_pkg;
    localparam int NUM_LANES   = 4;
    localparam int SCREEN_W    = 640;
    localparam int SCREEN_H    = 480;
    localparam int LANE_RED    = 0;
    localparam int LANE_GREEN  = 1;
    localparam int LANE_BLUE   = 2;
    localparam int LANE_YELLOW = 3;

    typedef enum logic [1:0] {
        GRADE_NONE,
        GRADE_OK,
        GRADE_GOOD,
        GRADE_MISS
    } grade_e;
endpackage

// File: rtl/hit_judge_if.sv
// Game-side signals of the hit judge: note/key inputs and score/HUD outputs.
interface hit_judge_if;
    logic                                 enable;
    logic                                 clear;
    logic [rhythm_pkg::NUM_LANES-1:0]     keys_n;
    logic [rhythm_pkg::NUM_LANES-1:0]     note_lanes;
    logic [9:0]                           note_y;
    logic [15:0]                          score;
    logic [7:0]                           combo;
    logic [7:0]                           max_combo;
    logic [7:0]                           miss_count;
    logic [rhythm_pkg::NUM_LANES-1:0]     hit_pulse;
    logic [rhythm_pkg::NUM_LANES-1:0]     good_pulse;
    logic                                 miss_pulse;
    logic                                 wrong_pulse;

    modport master (
        output enable, clear, keys_n, note_lanes, note_y,
        input  score, combo, max_combo, miss_count,
        input  hit_pulse, good_pulse, miss_pulse, wrong_pulse
    );

    modport slave (
        input  enable, clear, keys_n, note_lanes, note_y,
        output score, combo, max_combo, miss_count,
        output hit_pulse, good_pulse, miss_pulse, wrong_pulse
    );
endinterface

// File: rtl/key_debounce.sv
// One push-button: 2-FF synchroniser, down-counter debounce, one-cycle press pulse.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
)(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_key_n,
    output logic o_press
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    r_sync;
    logic          r_pressed;
    logic [CW-1:0] r_cnt;
    logic          r_press;
    logic          w_sample;

    assign w_sample = ~r_sync[1];
    assign o_press  = r_press;

    // Counter runs only while the sample disagrees with the debounced state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync    <= 2'b11;
            r_pressed <= 1'b0;
            r_cnt     <= RELOAD;
            r_press   <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_key_n};
            r_press <= 1'b0;
            if (w_sample == r_pressed) begin
                r_cnt <= RELOAD;
            end else if (r_cnt == '0) begin
                r_pressed <= w_sample;
                r_press   <= w_sample;
                r_cnt     <= RELOAD;
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end
endmodule

// File: rtl/hit_judge.sv
// Judges debounced key presses against the falling note and keeps score/combo/miss stats.
//   state    | meaning
//   ST_IDLE  | game paused: no judgement, counters hold
//   ST_PLAY  | game running: presses and misses are judged
module hit_judge
    import rhythm_pkg::*;
#(
    parameter int HIT_Y           = 440,
    parameter int WIN_GOOD        = 8,
    parameter int WIN_OK          = 24,
    parameter int PTS_GOOD        = 100,
    parameter int PTS_OK          = 50,
    parameter int DEBOUNCE_CYCLES = 250000
)(
    input  logic       i_clock_25,
    input  logic       i_reset_n,
    hit_judge_if.slave bus
);
    typedef enum logic {ST_IDLE, ST_PLAY} state_e;

    localparam logic [9:0]  HIT_Y_L    = 10'(HIT_Y);
    localparam logic [9:0]  WIN_GOOD_L = 10'(WIN_GOOD);
    localparam logic [9:0]  WIN_OK_L   = 10'(WIN_OK);
    localparam logic [9:0]  MISS_Y_L   = 10'(HIT_Y + WIN_OK);
    localparam logic [17:0] PTS_GOOD_L = 18'(PTS_GOOD);
    localparam logic [17:0] PTS_OK_L   = 18'(PTS_OK);

    state_e                 r_state, w_state_nxt;
    logic [9:0]             r_prev_y;
    logic [NUM_LANES-1:0]   r_pending, w_pending_nxt, w_pend_eff;
    logic [15:0]            r_score, w_score_nxt;
    logic [7:0]             r_combo, w_combo_nxt;
    logic [7:0]             r_max_combo, w_max_nxt;
    logic [7:0]             r_miss_count, w_miss_nxt;
    logic [NUM_LANES-1:0]   r_hit_pulse, r_good_pulse, w_hit, w_good;
    logic                   r_miss_pulse, r_wrong_pulse, w_miss, w_wrong;
    logic [NUM_LANES-1:0]   w_press;
    logic                   w_load;
    logic [9:0]             w_dist;
    logic [17:0]            w_pts, w_sum;
    logic [8:0]             w_csum;
    logic [2:0]             w_nhit;
    grade_e                 w_grade [NUM_LANES];

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_key
        key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
            .i_clk   (i_clock_25),
            .i_rst_n (i_reset_n),
            .i_key_n (bus.keys_n[g]),
            .o_press (w_press[g])
        );
    end

    always_ff @(posedge i_clock_25 or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state       <= ST_IDLE;
            r_prev_y      <= '0;
            r_pending     <= '0;
            r_score       <= '0;
            r_combo       <= '0;
            r_max_combo   <= '0;
            r_miss_count  <= '0;
            r_hit_pulse   <= '0;
            r_good_pulse  <= '0;
            r_miss_pulse  <= 1'b0;
            r_wrong_pulse <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_prev_y      <= bus.note_y;
            r_pending     <= w_pending_nxt;
            r_score       <= w_score_nxt;
            r_combo       <= w_combo_nxt;
            r_max_combo   <= w_max_nxt;
            r_miss_count  <= w_miss_nxt;
            r_hit_pulse   <= w_hit;
            r_good_pulse  <= w_good;
            r_miss_pulse  <= w_miss;
            r_wrong_pulse <= w_wrong;
        end
    end

    always_comb begin
        w_state_nxt   = bus.enable ? ST_PLAY : ST_IDLE;
        // Entering play, or the note wrapping back to the top, starts a new note.
        w_load        = (r_state == ST_IDLE) || (bus.note_y < r_prev_y);
        w_pend_eff    = w_load ? bus.note_lanes : r_pending;
        w_dist        = (bus.note_y >= HIT_Y_L) ? (bus.note_y - HIT_Y_L) : (HIT_Y_L - bus.note_y);
        w_pending_nxt = r_pending;
        w_score_nxt   = r_score;
        w_combo_nxt   = r_combo;
        w_max_nxt     = r_max_combo;
        w_miss_nxt    = r_miss_count;
        w_hit         = '0;
        w_good        = '0;
        w_miss        = 1'b0;
        w_wrong       = 1'b0;
        w_pts         = '0;
        w_sum         = '0;
        w_csum        = '0;
        w_nhit        = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            w_grade[i] = GRADE_NONE;
        end

        if (bus.enable) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (w_press[i]) begin
                    if (w_pend_eff[i] && (w_dist <= WIN_GOOD_L)) begin
                        w_grade[i] = GRADE_GOOD;
                    end else if (w_pend_eff[i] && (w_dist <= WIN_OK_L)) begin
                        w_grade[i] = GRADE_OK;
                    end else begin
                        w_wrong = 1'b1;
                    end
                end
            end
            for (int i = 0; i < NUM_LANES; i++) begin
                if (w_grade[i] == GRADE_GOOD) begin
                    w_hit[i]  = 1'b1;
                    w_good[i] = 1'b1;
                    w_pts     = w_pts + PTS_GOOD_L;
                    w_nhit    = w_nhit + 3'd1;
                end else if (w_grade[i] == GRADE_OK) begin
                    w_hit[i]  = 1'b1;
                    w_pts     = w_pts + PTS_OK_L;
                    w_nhit    = w_nhit + 3'd1;
                end
            end
            w_miss        = (w_pend_eff != '0) && (bus.note_y > MISS_Y_L);
            w_pending_nxt = w_miss ? '0 : (w_pend_eff & ~w_hit);
            w_sum         = {2'b00, r_score} + w_pts;
            w_score_nxt   = (w_sum > 18'h0FFFF) ? 16'hFFFF : w_sum[15:0];
            w_csum        = {1'b0, r_combo} + {6'b0, w_nhit};
            if (w_wrong || w_miss) begin
                w_combo_nxt = '0;
            end else begin
                w_combo_nxt = (w_csum > 9'd255) ? 8'hFF : w_csum[7:0];
            end
            w_max_nxt = (w_combo_nxt > r_max_combo) ? w_combo_nxt : r_max_combo;
            if (w_miss) begin
                w_miss_nxt = (r_miss_count == 8'hFF) ? 8'hFF : (r_miss_count + 8'd1);
            end
        end

        if (bus.clear) begin
            w_score_nxt = '0;
            w_combo_nxt = '0;
            w_max_nxt   = '0;
            w_miss_nxt  = '0;
        end
    end

    assign bus.score       = r_score;
    assign bus.combo       = r_combo;
    assign bus.max_combo   = r_max_combo;
    assign bus.miss_count  = r_miss_count;
    assign bus.hit_pulse   = r_hit_pulse;
    assign bus.good_pulse  = r_good_pulse;
    assign bus.miss_pulse  = r_miss_pulse;
    assign bus.wrong_pulse = r_wrong_pulse;
endmodule

// File: tb/tb_hit_judge.sv
// Bench for hit_judge: directed vector table, corner sequences, randomized notes vs a score model.
module tb_hit_judge;
    localparam int DB = 4;
    localparam int PW = DB + 5;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    logic [3:0] acc_hit, acc_good;
    int         cnt_wrong, cnt_miss;

    int m_score, m_combo, m_max, m_mcnt;

    typedef struct {
        bit         load;
        logic [3:0] lanes;
        int         y;
        logic [3:0] keys;
        logic [3:0] e_hit;
        logic [3:0] e_good;
        int         e_wrong;
        int         e_miss;
        int         e_score;
        int         e_combo;
        int         e_max;
        int         e_mcnt;
    } vec_t;

    vec_t tbl [10];

    hit_judge_if u_if ();

    hit_judge #(
        .HIT_Y(440), .WIN_GOOD(8), .WIN_OK(24),
        .PTS_GOOD(100), .PTS_OK(50), .DEBOUNCE_CYCLES(DB)
    ) dut (
        .i_clock_25 (clk),
        .i_reset_n  (rst_n),
        .bus        (u_if)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        acc_hit   = acc_hit | u_if.hit_pulse;
        acc_good  = acc_good | u_if.good_pulse;
        cnt_wrong = cnt_wrong + int'(u_if.wrong_pulse);
        cnt_miss  = cnt_miss + int'(u_if.miss_pulse);
    endtask

    task automatic clr_acc();
        acc_hit   = '0;
        acc_good  = '0;
        cnt_wrong = 0;
        cnt_miss  = 0;
    endtask

    task automatic press(input logic [3:0] keys);
        u_if.keys_n = ~keys;
        repeat (PW) step();
        u_if.keys_n = 4'hF;
        repeat (PW) step();
    endtask

    task automatic load_note(input logic [3:0] lanes, input int y);
        u_if.note_lanes = lanes;
        u_if.note_y     = 10'd0;
        step();
        u_if.note_y     = 10'(y);
        step();
    endtask

    task automatic check_stats(input string tag, input int s, input int c, input int mx, input int mc);
        check({tag, "_score"}, int'(u_if.score), s);
        check({tag, "_combo"}, int'(u_if.combo), c);
        check({tag, "_max"}, int'(u_if.max_combo), mx);
        check({tag, "_misscnt"}, int'(u_if.miss_count), mc);
    endtask

    // Reference scoring of one note: miss check at arrival, then one simultaneous press.
    task automatic model_note(input logic [3:0] lanes, input int y, input logic [3:0] keys,
                              output logic [3:0] e_hit, output logic [3:0] e_good,
                              output int e_wrong, output int e_miss);
        logic [3:0] pend;
        int d, pts, hits;
        pend = lanes; e_hit = '0; e_good = '0; e_wrong = 0; e_miss = 0; pts = 0; hits = 0;
        if (pend != 0 && y > 440 + 24) begin
            e_miss = 1;
            m_mcnt = (m_mcnt < 255) ? m_mcnt + 1 : 255;
            m_combo = 0;
            pend = '0;
        end
        d = (y > 440) ? y - 440 : 440 - y;
        for (int i = 0; i < 4; i++) begin
            if (keys[i]) begin
                if (pend[i] && d <= 8) begin
                    e_hit[i] = 1'b1; e_good[i] = 1'b1; pts += 100; hits++;
                end else if (pend[i] && d <= 24) begin
                    e_hit[i] = 1'b1; pts += 50; hits++;
                end else begin
                    e_wrong = 1;
                end
            end
        end
        m_score = (m_score + pts > 65535) ? 65535 : m_score + pts;
        if (e_wrong != 0) m_combo = 0;
        else m_combo = (m_combo + hits > 255) ? 255 : m_combo + hits;
        if (m_combo > m_max) m_max = m_combo;
    endtask

    initial begin
        logic [3:0] e_hit, e_good, lanes, keys;
        int e_wrong, e_miss, y;

        n_checks = 0;
        n_errors = 0;
        clr_acc();

        tbl[0] = '{1'b1, 4'b0001, 436, 4'b0001, 4'b0001, 4'b0001, 0, 0, 100, 1, 1, 0};
        tbl[1] = '{1'b1, 4'b0101, 460, 4'b0101, 4'b0101, 4'b0000, 0, 0, 200, 3, 3, 0};
        tbl[2] = '{1'b1, 4'b0011, 465, 4'b0000, 4'b0000, 4'b0000, 0, 1, 200, 0, 3, 1};
        tbl[3] = '{1'b0, 4'b0011, 465, 4'b0001, 4'b0000, 4'b0000, 1, 0, 200, 0, 3, 1};
        tbl[4] = '{1'b1, 4'b1000, 440, 4'b1000, 4'b1000, 4'b1000, 0, 0, 300, 1, 3, 1};
        tbl[5] = '{1'b1, 4'b0110, 430, 4'b0111, 4'b0110, 4'b0000, 1, 0, 400, 0, 3, 1};
        tbl[6] = '{1'b1, 4'b1111, 448, 4'b1111, 4'b1111, 4'b1111, 0, 0, 800, 4, 4, 1};
        tbl[7] = '{1'b1, 4'b0001, 416, 4'b0001, 4'b0001, 4'b0000, 0, 0, 850, 5, 5, 1};
        tbl[8] = '{1'b1, 4'b0001, 415, 4'b0001, 4'b0000, 4'b0000, 1, 0, 850, 0, 5, 1};
        tbl[9] = '{1'b1, 4'b0010, 464, 4'b0010, 4'b0010, 4'b0000, 0, 0, 900, 1, 5, 1};

        // Reset with keys held; keys released shortly after reset goes away.
        rst_n           = 1'b0;
        u_if.enable     = 1'b0;
        u_if.clear      = 1'b0;
        u_if.keys_n     = 4'h0;
        u_if.note_lanes = 4'h0;
        u_if.note_y     = 10'd100;
        repeat (3) @(posedge clk);
        #1;
        check_stats("reset", int'(u_if.score), 0, 0, 0);
        check("reset_score", int'(u_if.score), 0);
        check("reset_hit", int'(u_if.hit_pulse), 0);
        check("reset_wrong", int'(u_if.wrong_pulse), 0);
        rst_n       = 1'b1;
        u_if.enable = 1'b1;
        step();
        step();
        u_if.keys_n = 4'hF;
        clr_acc();
        repeat (20) step();
        check("post_reset_wrong", cnt_wrong, 0);
        check("post_reset_hit", int'(acc_hit), 0);
        check("post_reset_miss", cnt_miss, 0);

        for (int r = 0; r < 10; r++) begin
            clr_acc();
            if (tbl[r].load) begin
                load_note(tbl[r].lanes, tbl[r].y);
            end else begin
                u_if.note_y = 10'(tbl[r].y);
                step();
            end
            press(tbl[r].keys);
            check($sformatf("row%0d_hit", r), int'(acc_hit), int'(tbl[r].e_hit));
            check($sformatf("row%0d_good", r), int'(acc_good), int'(tbl[r].e_good));
            check($sformatf("row%0d_wrong", r), cnt_wrong, tbl[r].e_wrong);
            check($sformatf("row%0d_miss", r), cnt_miss, tbl[r].e_miss);
            check_stats($sformatf("row%0d", r), tbl[r].e_score, tbl[r].e_combo,
                        tbl[r].e_max, tbl[r].e_mcnt);
        end

        // Bouncing key1 must collapse into a single press.
        load_note(4'b0001, 440);
        clr_acc();
        for (int k = 0; k < 5; k++) begin
            u_if.keys_n = 4'b1101; step(); step();
            u_if.keys_n = 4'hF;    step(); step();
        end
        press(4'b0010);
        check("bounce_wrong", cnt_wrong, 1);
        check("bounce_hit", int'(acc_hit), 0);
        check_stats("bounce", 900, 0, 5, 1);

        // Miss boundary: 464 is still in the window, 465 is a miss, counted once.
        load_note(4'b0011, 440);
        clr_acc();
        u_if.note_y = 10'd450; step();
        u_if.note_y = 10'd460; step();
        u_if.note_y = 10'd464; step();
        check("miss_edge_464", cnt_miss, 0);
        u_if.note_y = 10'd465; step();
        u_if.note_y = 10'd470; step();
        u_if.note_y = 10'd480; step();
        check("miss_once", cnt_miss, 1);
        check_stats("miss", 900, 0, 5, 2);
        clr_acc();
        press(4'b0001);
        check("late_press_wrong", cnt_wrong, 1);
        check("late_press_hit", int'(acc_hit), 0);

        // Disabled game ignores presses; re-enable reloads the current note.
        load_note(4'b0001, 440);
        u_if.enable = 1'b0;
        clr_acc();
        press(4'b0001);
        check("idle_hit", int'(acc_hit), 0);
        check("idle_wrong", cnt_wrong, 0);
        check("idle_score", int'(u_if.score), 900);
        u_if.enable = 1'b1;
        step();
        clr_acc();
        press(4'b0001);
        check("reenable_good", int'(acc_good), 1);
        check_stats("reenable", 1000, 1, 5, 2);

        // Saturation from a cleared state.
        u_if.clear = 1'b1;
        step();
        u_if.clear = 1'b0;
        check_stats("clear1", 0, 0, 0, 0);
        for (int n = 0; n < 655; n++) begin
            load_note(4'b0001, 440);
            press(4'b0001);
        end
        check_stats("sat655", 65500, 255, 255, 0);
        load_note(4'b0001, 440);
        press(4'b0001);
        check("sat656_score", int'(u_if.score), 65535);
        load_note(4'b0001, 440);
        press(4'b0001);
        check("sat657_score", int'(u_if.score), 65535);
        u_if.clear = 1'b1;
        step();
        u_if.clear = 1'b0;
        check_stats("clear2", 0, 0, 0, 0);

        m_score = 0; m_combo = 0; m_max = 0; m_mcnt = 0;
        for (int it = 0; it < 150; it++) begin
            lanes = 4'($urandom_range(0, 15));
            keys  = 4'($urandom_range(0, 15));
            y     = ($urandom_range(0, 1) == 0) ? int'($urandom_range(410, 470))
                                                : int'($urandom_range(1, 480));
            clr_acc();
            load_note(lanes, y);
            press(keys);
            model_note(lanes, y, keys, e_hit, e_good, e_wrong, e_miss);
            check($sformatf("rnd%0d_hit", it), int'(acc_hit), int'(e_hit));
            check($sformatf("rnd%0d_good", it), int'(acc_good), int'(e_good));
            check($sformatf("rnd%0d_wrong", it), cnt_wrong, e_wrong);
            check($sformatf("rnd%0d_miss", it), cnt_miss, e_miss);
            check_stats($sformatf("rnd%0d", it), m_score, m_combo, m_max, m_mcnt);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
